// File: rtl/int_ctrl_pkg.sv
// int_ctrl shared constants: register offsets,
// CTRL field positions and bus direction encoding.
package int_ctrl_pkg;

  localparam logic [4:0] OFS_RAW  = 5'h00;
  localparam logic [4:0] OFS_PEND = 5'h04;
  localparam logic [4:0] OFS_MASK = 5'h08;
  localparam logic [4:0] OFS_STAT = 5'h0C;
  localparam logic [4:0] OFS_CTRL = 5'h10;

  localparam int GEN_BIT  = 0;
  localparam int HOLD_LSB = 8;
  localparam int HOLD_W   = 8;

  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/int_holdoff.sv
// Irq hold-off timer: reloads HOLD while idle,
// counts down to 0 while STAT is live, then fires.
module int_holdoff #(
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gen,
  input  logic              active,
  input  logic [HOLD_W-1:0] hold,
  output logic              irq
);

  logic [HOLD_W-1:0] tmr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= '0;
      irq <= 1'b0;
    end else begin
      if (!gen || !active) begin
        tmr <= hold;
      end else if (tmr != '0) begin
        tmr <= tmr - 1'b1;
      end
      irq <= gen && active && (tmr == '0);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt aggregator: edge capture, W1C pend, mask,
// global enable, hold-off. Option: INT_CTRL_SYNC_EN.
module int_ctrl #(
  parameter int         N_SRC = 2,
  parameter logic [7:0] BASE  = 8'h00
) (
  input  logic             clk,
  input  logic             xrst,
  input  logic             cs,
  input  logic             rw,
  input  logic [7:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [N_SRC-1:0] int_src,
  output logic             irq
);

  import int_ctrl_pkg::*;

  logic [N_SRC-1:0]  src;
  logic [N_SRC-1:0]  src_d;
  logic [N_SRC-1:0]  rise;
  logic [N_SRC-1:0]  clr;
  logic [N_SRC-1:0]  pend;
  logic [N_SRC-1:0]  mask;
  logic [N_SRC-1:0]  stat;
  logic              run;
  logic              gen;
  logic [HOLD_W-1:0] hold;
  logic              hit;
  logic              wr_en;
  logic              rd_en;
  logic [4:0]        ofs;
  logic [31:0]       rd_val;
  logic              unused_ok;

`ifdef INT_CTRL_SYNC_EN
  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] sync2;

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= int_src;
      sync2 <= sync1;
    end
  end

  assign src = sync2;
`else
  assign src = int_src;
`endif

  assign hit   = cs && (addr[7:5] == BASE[7:5]);
  assign ofs   = addr[4:0];
  assign wr_en = hit && (rw == RW_WRITE);
  assign rd_en = cs && (rw != RW_WRITE);

  // run gates the first clock so a level already high
  // at reset release is not taken as an edge
  assign rise = src & ~src_d & {N_SRC{run}};
  assign clr  = (wr_en && ofs == OFS_PEND) ?
                wdata[N_SRC-1:0] : '0;
  assign stat = pend & mask;

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      src_d <= '0;
      run   <= 1'b0;
      pend  <= '0;
      mask  <= '0;
      gen   <= 1'b0;
      hold  <= '0;
    end else begin
      src_d <= src;
      run   <= 1'b1;
      pend  <= (pend & ~clr) | rise;
      if (wr_en && ofs == OFS_MASK) begin
        mask <= wdata[N_SRC-1:0];
      end
      if (wr_en && ofs == OFS_CTRL) begin
        gen  <= wdata[GEN_BIT];
        hold <= wdata[HOLD_LSB +: HOLD_W];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (ofs)
        OFS_RAW:  rd_val = 32'(src);
        OFS_PEND: rd_val = 32'(pend);
        OFS_MASK: rd_val = 32'(mask);
        OFS_STAT: rd_val = 32'(stat);
        OFS_CTRL: begin
          rd_val[GEN_BIT]            = gen;
          rd_val[HOLD_LSB +: HOLD_W] = hold;
        end
        default:  rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_val;
    end
  end

  int_holdoff #(
    .HOLD_W (HOLD_W)
  ) u_holdoff (
    .clk    (clk),
    .rst    (xrst),
    .gen    (gen),
    .active (stat != '0),
    .hold   (hold),
    .irq    (irq)
  );

  assign unused_ok = ^wdata;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: edge capture, W1C,
// mask, hold-off latency and async reset.
module tb_int_ctrl;

  localparam logic [7:0] A_RAW  = 8'h00;
  localparam logic [7:0] A_PEND = 8'h04;
  localparam logic [7:0] A_MASK = 8'h08;
  localparam logic [7:0] A_STAT = 8'h0C;
  localparam logic [7:0] A_CTRL = 8'h10;

  logic        clk;
  logic        xrst;
  logic        cs;
  logic        rw;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  int_src;
  logic        irq;

  int errors;
  int checks;

  int_ctrl #(
    .N_SRC (2),
    .BASE  (8'h00)
  ) dut (
    .clk     (clk),
    .xrst    (xrst),
    .cs      (cs),
    .rw      (rw),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .int_src (int_src),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a,
                    input logic [31:0] d);
    cs = 1'b1; rw = 1'b1; addr = a; wdata = d;
    tick();
    cs = 1'b0; rw = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [7:0] a,
                    output logic [31:0] d);
    cs = 1'b1; rw = 1'b0; addr = a;
    tick();
    cs = 1'b0;
    d = rdata;
  endtask

  initial begin
    logic [31:0] v;
    int          lat;
    logic        seen;
    errors = 0; checks = 0;
    cs = 0; rw = 0; addr = 0; wdata = 0;
    int_src = 2'b00;
    xrst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_irq", 32'(irq), 0);
    chk("rst_rdata", rdata, 0);
    xrst = 1'b0;
    tick();
    rd(A_PEND, v); chk("rst_pend", v, 0);
    rd(A_MASK, v); chk("rst_mask", v, 0);
    rd(A_CTRL, v); chk("rst_ctrl", v, 0);
    rd(A_STAT, v); chk("rst_stat", v, 0);

    // 1: basic path with HOLD=0
    wr(A_CTRL, 32'h1);
    wr(A_MASK, 32'h1);
    int_src[0] = 1'b1;
    tick(); chk("s1_irq_early", 32'(irq), 0);
    tick(); chk("s1_irq_rise", 32'(irq), 1);
    rd(A_PEND, v); chk("s1_pend", v, 1);
    rd(A_STAT, v); chk("s1_stat", v, 1);
    wr(A_PEND, 32'h1);
    chk("s1_irq_hold", 32'(irq), 1);
    tick(); chk("s1_irq_drop", 32'(irq), 0);
    int_src[0] = 1'b0;
    tick();

    // 2: held level sets pend once
    wr(A_MASK, 32'h2);
    int_src[1] = 1'b1;
    tick(); tick();
    chk("s2_irq", 32'(irq), 1);
    rd(A_PEND, v); chk("s2_pend", v, 2);
    wr(A_PEND, 32'h2);
    repeat (15) tick();
    rd(A_PEND, v); chk("s2_pend_clr", v, 0);
    chk("s2_irq_off", 32'(irq), 0);
    int_src[1] = 1'b0;
    tick();

    // 3: set wins over same-cycle W1C
    int_src[0] = 1'b1; tick();
    int_src[0] = 1'b0; tick();
    rd(A_PEND, v); chk("s3_pre", v, 1);
    int_src[0] = 1'b1;
    wr(A_PEND, 32'h1);
    rd(A_PEND, v); chk("s3_set_wins", v, 1);
    wr(A_PEND, 32'h1);
    rd(A_PEND, v); chk("s3_clr", v, 0);
    int_src[0] = 1'b0;
    tick();

    // 4: HOLD=5 adds 5 cycles
    wr(A_CTRL, 32'h0501);
    wr(A_MASK, 32'h3);
    int_src[0] = 1'b1;
    lat = 0;
    while (!irq && lat < 20) begin
      tick();
      lat++;
    end
    chk("s4_lat", 32'(lat), 7);
    wr(A_PEND, 32'h1);
    tick(); chk("s4_drop", 32'(irq), 0);
    int_src[0] = 1'b0; tick();
    int_src[0] = 1'b1;
    tick(); tick(); tick();
    wr(A_PEND, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen |= irq;
    end
    chk("s4_no_irq", 32'(seen), 0);

    // 5: mask gating, HOLD=2
    wr(A_CTRL, 32'h0201);
    wr(A_MASK, 32'h0);
    int_src[1] = 1'b1;
    tick(); tick();
    rd(A_PEND, v); chk("s5_pend", v, 2);
    rd(A_STAT, v); chk("s5_stat0", v, 0);
    chk("s5_irq0", 32'(irq), 0);
    wr(A_MASK, 32'h2);
    rd(A_STAT, v); chk("s5_stat", v, 2);
    chk("s5_irq_m1", 32'(irq), 0);
    tick(); chk("s5_irq_m2", 32'(irq), 0);
    tick(); chk("s5_irq_m3", 32'(irq), 1);
    rd(A_RAW, v);  chk("s5_raw", v, 3);
    rd(A_CTRL, v); chk("s5_ctrl", v, 32'h0201);
    rd(8'h14, v);  chk("s5_unmapped", v, 0);
    rd(8'h24, v);  chk("s5_base_miss", v, 0);

    // 6: async reset mid-operation
    wr(A_CTRL, 32'h1);
    wr(A_MASK, 32'h3);
    int_src[0] = 1'b0; tick();
    int_src[0] = 1'b1; tick();
    tick();
    chk("s6_irq", 32'(irq), 1);
    rd(A_PEND, v); chk("s6_pend", v, 3);
    #2 xrst = 1'b1;
    #1;
    chk("s6_rst_irq", 32'(irq), 0);
    chk("s6_rst_rdata", rdata, 0);
    repeat (2) @(posedge clk);
    #1 xrst = 1'b0;
    repeat (3) tick();
    rd(A_PEND, v); chk("s6_no_pend", v, 0);
    rd(A_MASK, v); chk("s6_mask", v, 0);
    rd(A_CTRL, v); chk("s6_ctrl", v, 0);
    chk("s6_irq_after", 32'(irq), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
